// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: eight-way round-robin arbiter with request/grant/done handshake.
// Define ARB_TIMEOUT_EN to compile in the MAX_HOLD tenure limit and timeout pulse.
module rr_arbiter_8 #(
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] d,
   input  logic       done,
   output logic [7:0] gnt,
   output logic [2:0] a,
   output logic       gnt_valid,
   output logic       timeout
);

   typedef enum logic {IDLE, OWN} state_t;

   state_t     state_q, state_d;
   logic [2:0] ptr_q, ptr_d;
   logic [2:0] a_q, a_d;
   logic [7:0] gnt_q, gnt_d;
   logic       vld_q, vld_d;
   logic [7:0] rot;
   logic [2:0] sel;
   logic       rel;

   if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
      $error("rr_arbiter_8: MAX_HOLD must be 1..255");
   end

`ifdef ARB_TIMEOUT_EN
   logic [7:0] hold_q, hold_d;
   logic       to_q, to_d;
   logic       expire;

   assign expire = (hold_q == 8'(MAX_HOLD - 1));
`endif

   // rot[j] is requester ptr+j, so the lowest set bit is the next in turn
   always_comb begin
      rot = 8'({d, d} >> ptr_q);
      sel = 3'd0;
      for (int j = 7; j >= 0; j--) begin
         if (rot[j]) sel = j[2:0];
      end
   end

   assign rel = done || !d[a_q];

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      a_d     = a_q;
      gnt_d   = gnt_q;
      vld_d   = vld_q;
`ifdef ARB_TIMEOUT_EN
      hold_d  = hold_q;
      to_d    = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            if (|d) begin
               state_d = OWN;
               a_d     = ptr_q + sel;
               gnt_d   = 8'b1 << a_d;
               vld_d   = 1'b1;
`ifdef ARB_TIMEOUT_EN
               hold_d  = 8'd0;
`endif
            end
         end
         OWN: begin
`ifdef ARB_TIMEOUT_EN
            if (rel || expire) begin
               to_d = !rel;
`else
            if (rel) begin
`endif
               state_d = IDLE;
               ptr_d   = a_q + 3'd1;
               a_d     = 3'd0;
               gnt_d   = 8'd0;
               vld_d   = 1'b0;
            end
`ifdef ARB_TIMEOUT_EN
            else if (hold_q != 8'hFF) begin
               hold_d = hold_q + 8'd1;
            end
`endif
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= 3'd0;
         a_q     <= 3'd0;
         gnt_q   <= 8'd0;
         vld_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         hold_q  <= 8'd0;
         to_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         a_q     <= a_d;
         gnt_q   <= gnt_d;
         vld_q   <= vld_d;
`ifdef ARB_TIMEOUT_EN
         hold_q  <= hold_d;
         to_q    <= to_d;
`endif
      end
   end

   assign gnt       = gnt_q;
   assign a         = a_q;
   assign gnt_valid = vld_q;
`ifdef ARB_TIMEOUT_EN
   assign timeout   = to_q;
`else
   assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb_rr_arbiter_8: scoreboard bench for rr_arbiter_8 (MAX_HOLD=4).
// Each row drives inputs, queues the expected registered outputs, then compares.
module tb_rr_arbiter_8;

   logic       clk;
   logic       rst_n;
   logic [7:0] d;
   logic       done;
   logic [7:0] gnt;
   logic [2:0] a;
   logic       gnt_valid;
   logic       timeout;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct packed {
      logic        rn;
      logic [7:0]  dd;
      logic        dn;
      logic [12:0] exp;
   } row_t;

   logic [12:0] sb[$];

   rr_arbiter_8 #(.MAX_HOLD(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .d         (d),
      .done      (done),
      .gnt       (gnt),
      .a         (a),
      .gnt_valid (gnt_valid),
      .timeout   (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // expected {gnt, a, gnt_valid, timeout} after the edge that samples this row
   function automatic row_t r(logic rn, logic [7:0] dd, logic dn,
                              int idx, logic v, logic to);
      row_t x;
      logic [7:0] g;
      g = v ? (8'b1 << idx) : 8'd0;
      x.rn  = rn;
      x.dd  = dd;
      x.dn  = dn;
      x.exp = {g, v ? 3'(idx) : 3'd0, v, to};
      return x;
   endfunction

   task automatic test_reset();
      row_t rows[$];
      logic [12:0] got, want;
      rows.push_back(r(0, 8'h00, 0, 0, 0, 0));
      rows.push_back(r(0, 8'h00, 0, 0, 0, 0));
      rows.push_back(r(1, 8'h08, 0, 3, 1, 0));
      rows.push_back(r(1, 8'h08, 0, 3, 1, 0));
      rows.push_back(r(0, 8'h08, 0, 0, 0, 0));
      rows.push_back(r(1, 8'hFF, 0, 0, 1, 0));
      rows.push_back(r(1, 8'hFF, 1, 0, 0, 0));
      foreach (rows[i]) begin
         rst_n = rows[i].rn; d = rows[i].dd; done = rows[i].dn;
         sb.push_back(rows[i].exp);
         @(posedge clk); #1;
         got = {gnt, a, gnt_valid, timeout};
         want = sb.pop_front();
         n_chk++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL reset[%0d]: got gnt/a/v/to=%h want %h", i, got, want);
         end
      end
   endtask

   task automatic test_rotation();
      row_t rows[$];
      logic [12:0] got, want;
      rows.push_back(r(0, 8'h00, 0, 0, 0, 0));
      for (int k = 0; k < 9; k++) begin
         rows.push_back(r(1, 8'hFF, 0, k % 8, 1, 0));
         rows.push_back(r(1, 8'hFF, 1, 0, 0, 0));
      end
      foreach (rows[i]) begin
         rst_n = rows[i].rn; d = rows[i].dd; done = rows[i].dn;
         sb.push_back(rows[i].exp);
         @(posedge clk); #1;
         got = {gnt, a, gnt_valid, timeout};
         want = sb.pop_front();
         n_chk++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL rotation[%0d]: got gnt/a/v/to=%h want %h", i, got, want);
         end
      end
   endtask

   task automatic test_wrap_skip();
      row_t rows[$];
      logic [12:0] got, want;
      rows.push_back(r(1, 8'h20, 0, 5, 1, 0));
      rows.push_back(r(1, 8'h20, 1, 0, 0, 0));
      rows.push_back(r(1, 8'h05, 0, 0, 1, 0));
      rows.push_back(r(1, 8'h05, 1, 0, 0, 0));
      rows.push_back(r(1, 8'h05, 0, 2, 1, 0));
      rows.push_back(r(1, 8'h05, 1, 0, 0, 0));
      foreach (rows[i]) begin
         rst_n = rows[i].rn; d = rows[i].dd; done = rows[i].dn;
         sb.push_back(rows[i].exp);
         @(posedge clk); #1;
         got = {gnt, a, gnt_valid, timeout};
         want = sb.pop_front();
         n_chk++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL wrap[%0d]: got gnt/a/v/to=%h want %h", i, got, want);
         end
      end
   endtask

   task automatic test_withdraw();
      row_t rows[$];
      logic [12:0] got, want;
      rows.push_back(r(1, 8'h10, 0, 4, 1, 0));
      rows.push_back(r(1, 8'h00, 0, 0, 0, 0));
      rows.push_back(r(1, 8'h11, 0, 0, 1, 0));
      rows.push_back(r(1, 8'h11, 1, 0, 0, 0));
      rows.push_back(r(1, 8'h10, 0, 4, 1, 0));
      rows.push_back(r(1, 8'h00, 1, 0, 0, 0));
      rows.push_back(r(1, 8'h21, 0, 5, 1, 0));
      rows.push_back(r(1, 8'h21, 1, 0, 0, 0));
      foreach (rows[i]) begin
         rst_n = rows[i].rn; d = rows[i].dd; done = rows[i].dn;
         sb.push_back(rows[i].exp);
         @(posedge clk); #1;
         got = {gnt, a, gnt_valid, timeout};
         want = sb.pop_front();
         n_chk++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL withdraw[%0d]: got gnt/a/v/to=%h want %h", i, got, want);
         end
      end
   endtask

   task automatic test_idle();
      row_t rows[$];
      logic [12:0] got, want;
      for (int k = 0; k < 10; k++) rows.push_back(r(1, 8'h00, 0, 0, 0, 0));
      rows.push_back(r(1, 8'h40, 0, 6, 1, 0));
      rows.push_back(r(1, 8'h40, 1, 0, 0, 0));
      foreach (rows[i]) begin
         rst_n = rows[i].rn; d = rows[i].dd; done = rows[i].dn;
         sb.push_back(rows[i].exp);
         @(posedge clk); #1;
         got = {gnt, a, gnt_valid, timeout};
         want = sb.pop_front();
         n_chk++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL idle[%0d]: got gnt/a/v/to=%h want %h", i, got, want);
         end
      end
   endtask

   task automatic test_timeout();
      row_t rows[$];
      logic [12:0] got, want;
`ifdef ARB_TIMEOUT_EN
      for (int k = 0; k < 4; k++) rows.push_back(r(1, 8'h02, 0, 1, 1, 0));
      rows.push_back(r(1, 8'h02, 0, 0, 0, 1));
      for (int k = 0; k < 4; k++) rows.push_back(r(1, 8'h06, 0, 2, 1, 0));
      rows.push_back(r(1, 8'h06, 1, 0, 0, 0));
      rows.push_back(r(1, 8'h00, 0, 0, 0, 0));
`else
      for (int k = 0; k < 100; k++) rows.push_back(r(1, 8'h02, 0, 1, 1, 0));
      rows.push_back(r(1, 8'h02, 1, 0, 0, 0));
`endif
      foreach (rows[i]) begin
         rst_n = rows[i].rn; d = rows[i].dd; done = rows[i].dn;
         sb.push_back(rows[i].exp);
         @(posedge clk); #1;
         got = {gnt, a, gnt_valid, timeout};
         want = sb.pop_front();
         n_chk++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL timeout[%0d]: got gnt/a/v/to=%h want %h", i, got, want);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      d     = 8'h00;
      done  = 1'b0;
      test_reset();
      test_rotation();
      test_wrap_skip();
      test_withdraw();
      test_idle();
      test_timeout();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/rr_arbiter_8.md
# rr_arbiter_8

Round-robin arbiter granting one of eight requesters access to a shared resource. It reuses the 8-to-3 encoding convention of the priority encoder (one-hot/priority inputs to a 3-bit index plus a valid flag), but replaces fixed priority with a rotating pointer so no requester starves. It sits in front of any shared datapath, such as a bus or ALU port, and sequences ownership through a request/grant/done handshake.

## Interface
- MAX_HOLD, 16: maximum grant tenure in cycles. Used only when ARB_TIMEOUT_EN is defined. Legal range is 1..255.
- clk  input  1  clock; all logic updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- d  input  8  request vector; d[i]=1 means requester i wants the resource.
- done  input  1  current owner releases the resource. Ignored unless gnt_valid=1.
- gnt  output  8  one-hot grant; all zero when there is no owner.
- a  output  3  index of the granted requester; 0 when gnt_valid=0.
- gnt_valid  output  1  a grant is active.
- timeout  output  1  one-cycle pulse when a grant is force-released.

## Operation
- State machine with states IDLE and OWN.
- Reset (rst_n=0 at a clock edge) sets: state=IDLE, ptr=0, gnt=0, a=0, gnt_valid=0, timeout=0, hold counter=0.
  - Reset overrides everything, including a grant held mid-tenure.
- IDLE:
  - If d=0, remain in IDLE.
  - Otherwise select the first set bit scanning ptr, ptr+1, …, ptr+7 (mod 8). Register gnt/a/gnt_valid for that requester and go to OWN.
- OWN releases on any of these conditions, in priority order:
  - done=1;
  - d[a]=0 (requester withdrew);
  - with ARB_TIMEOUT_EN, hold counter reaches MAX_HOLD-1.
- On release:
  - ptr ← a+1, using 3-bit wrap (7 → 0);
  - gnt ← 0, gnt_valid ← 0, a ← 0;
  - go to IDLE.
- Requests from other requesters during OWN are ignored until the next IDLE cycle. Requests are not latched: a requester must hold d[i] high until granted.
- Outputs are registered. gnt is always either zero or exactly one-hot, and gnt[a]=1 whenever gnt_valid=1.

## Timing
- Grant latency: d sampled at edge k in IDLE produces gnt valid after edge k (visible in cycle k+1).
- Release: done or a withdrawn request sampled at edge k clears gnt after edge k.
- Mandatory 1-cycle IDLE gap between consecutive grants. The minimum period per tenure is 2 cycles (1 OWN + 1 IDLE).
- done and request withdrawal in the same cycle count as a single release.
- Hold counter:
  - cleared on entry to OWN;
  - increments each OWN cycle;
  - saturates at 8 bits.
- Worst-case wait for a continuously requesting input is 7 tenures plus 8 gap cycles.

## Configuration
- ARB_TIMEOUT_EN defined:
  - The hold counter is compiled in.
  - The OWN cycle in which the counter equals MAX_HOLD-1 forces release.
  - timeout pulses 1 in the cycle immediately after the forced release, together with gnt=0.
  - If done arrives in the same cycle as the timeout condition, it takes priority and timeout stays 0.
- ARB_TIMEOUT_EN undefined:
  - No counter logic.
  - timeout is tied to 0.
  - A grant persists indefinitely while d[a]=1 and done=0.

## Test plan
- Reset mid-grant: requester 3 owns; assert rst_n=0 for one edge → gnt=0, a=0, gnt_valid=0, ptr=0. With d=8'hFF afterwards, the first grant goes to requester 0.
- Rotation: hold d=8'hFF and pulse done in each OWN cycle → grant sequence 0,1,2,…,7,0 with a matching each index and a 1-cycle gap between grants.
- Wrap/skip: ptr=6 (after requester 5 releases), d=8'b0000_0101 → grant to requester 0 (a=0), then requester 2.
- Withdrawal: requester 4 owns and d[4] drops with done=0 → gnt=0 on the next edge, ptr=5. d=8'b0001_0000 alone then re-grants requester 4.
- Idle: d=0 for 10 cycles → gnt_valid=0 and a=0 throughout; no state change.
- Timeout (ARB_TIMEOUT_EN, MAX_HOLD=4): requester 1 holds with done=0 → gnt_valid stays 1 for exactly 4 cycles, then gnt=0 with timeout=1 for one cycle, and the next grant goes to the next requester after 1. Without the macro, gnt persists for 100 cycles and timeout stays 0.
